panel_event_arbiter: RTL

Collects single-cycle event pulses from up to N front-panel button debouncers and delivers them one at a time to a single consumer, such as the executor command decoder, over a valid/ack handshake. Pulses are latched as pending flags and served in round-robin order, so simultaneous presses are neither lost nor starved. Lost events are reported through sticky flags:
- a second press while the first is still pending (overrun);
- an event the consumer never acknowledges (timeout).

---
 rtl/panel_event_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/panel_event_arbiter.sv
// Front-panel event arbiter: latches debouncer pulses as pending flags and
// offers them one at a time, round-robin, over a valid/ack handshake.
module panel_event_arbiter #(
  parameter int          N_BUTTONS   = 4,
  parameter int          CODE_WIDTH  = 2,
  parameter logic [15:0] ACK_TIMEOUT = 16'd1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_BUTTONS-1:0]  btn_pulse,
  output logic                  evt_valid,
  output logic [CODE_WIDTH-1:0] evt_code,
  input  logic                  evt_ack,
  output logic [N_BUTTONS-1:0]  overrun,
  output logic                  timeout_err,
  input  logic                  clear_flags,
  output logic [1:0]            o_dbg_state
);

  // Handshake: evt_valid is high only in OFFER, evt_code is stable while it is
  // high, and evt_ack is honoured only in a cycle where evt_valid is high.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_evt_valid;
  logic [CODE_WIDTH-1:0] r_evt_code;
  logic [CODE_WIDTH-1:0] r_rr_ptr;
  logic [15:0]           r_cnt;
  logic [N_BUTTONS-1:0]  r_pending;
  logic [N_BUTTONS-1:0]  r_overrun;
  logic                  r_timeout_err;

  logic                  w_take_ack;
  logic                  w_take_to;
  logic                  w_release;
  logic [N_BUTTONS-1:0]  w_clr_mask;
  logic [N_BUTTONS-1:0]  w_ovr_set;
  logic [N_BUTTONS-1:0]  w_pending_nxt;
  logic [CODE_WIDTH-1:0] w_rr_nxt;
  logic                  w_found;
  logic [CODE_WIDTH-1:0] w_sel;

  assign w_take_ack = (r_state == S_OFFER) && evt_ack;
  assign w_take_to  = (r_state == S_OFFER) && !evt_ack && (r_cnt == ACK_TIMEOUT - 16'd1);
  assign w_release  = w_take_ack || w_take_to;

  // A pulse on the button being released this cycle is a fresh event, not an overrun.
  assign w_clr_mask    = w_release ? (N_BUTTONS'(1) << r_evt_code) : '0;
  assign w_ovr_set     = btn_pulse & r_pending & ~w_clr_mask;
  assign w_pending_nxt = (r_pending & ~w_clr_mask) | btn_pulse;
  assign w_rr_nxt      = (int'(r_evt_code) >= N_BUTTONS - 1) ? '0 : r_evt_code + 1'b1;

  // First pending button at or after the round-robin pointer, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < N_BUTTONS; k++) begin
      idx = (int'(r_rr_ptr) + k) % N_BUTTONS;
      if (!w_found && ((r_pending & (N_BUTTONS'(1) << idx)) != '0)) begin
        w_found = 1'b1;
        w_sel   = CODE_WIDTH'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_overrun <= clear_flags ? w_ovr_set : (r_overrun | w_ovr_set);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_evt_valid   <= 1'b0;
      r_evt_code    <= '0;
      r_rr_ptr      <= '0;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (clear_flags) r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_evt_code  <= w_sel;
            r_evt_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (w_take_ack) begin
            r_evt_valid <= 1'b0;
            r_rr_ptr    <= w_rr_nxt;
            r_state     <= S_GAP;
          end else if (w_take_to) begin
            // Setting the sticky flag overrides a simultaneous clear above.
            r_timeout_err <= 1'b1;
            r_evt_valid   <= 1'b0;
            r_rr_ptr      <= w_rr_nxt;
            r_state       <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_GAP: begin
          r_evt_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_evt_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign evt_valid   = r_evt_valid;
  assign evt_code    = r_evt_code;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;
  assign o_dbg_state = r_state;

endmodule
